// File: rtl/xyolo_packer.sv
// rtl/xyolo_packer.sv - packs 16-bit reduced results two per word into a FIFO-buffered memory write port
// Optional saturation is enabled by defining XYOLO_PACK_SAT_EN.
module xyolo_packer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   n_out,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic [3:0]        m_strb,
    output logic              done,
    output logic              overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_DRAIN, S_DONE} state_t;

    state_t             state;
    logic [DATA_W+3:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [ADDR_W:0]    n_lat;
    logic [ADDR_W:0]    taken;
    logic [ADDR_W:0]    taken_nxt;
    logic               half;
    logic [15:0]        lo;
    logic [15:0]        red;
    logic               take;
    logic               last;
    logic               push;
    logic               push_ok;
    logic               pop;
    logic [DATA_W+3:0]  push_word;

`ifdef XYOLO_PACK_SAT_EN
    always_comb begin
        red = in_data[15:0];
        if ($signed(in_data) > 32'sd32767) begin
            red = 16'h7FFF;
        end else if ($signed(in_data) < -32'sd32768) begin
            red = 16'h8000;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^in_data[DATA_W-1:16];
    assign red       = in_data[15:0];
`endif

    // A run in the same cycle as a strobe wins; the strobe is dropped.
    assign take      = (state == S_PACK) && in_valid && !run;
    assign taken_nxt = taken + 1'b1;
    assign last      = (taken_nxt == n_lat);
    assign push      = take && (half || last);
    assign push_word = half ? {4'b1111, red, lo} : {4'b0011, 16'h0000, red};
    assign m_valid   = (count != '0);
    assign pop       = m_valid && m_ready;
    assign push_ok   = push && ((count != FULL) || pop);
    assign m_data    = m_valid ? mem[rd_ptr][DATA_W-1:0] : '0;
    assign m_strb    = m_valid ? mem[rd_ptr][DATA_W+3:DATA_W] : 4'b0000;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            n_lat    <= '0;
            taken    <= '0;
            half     <= 1'b0;
            lo       <= '0;
            m_addr   <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else if (run) begin
            state    <= (n_out == '0) ? S_DONE : S_PACK;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            n_lat    <= n_out;
            taken    <= '0;
            half     <= 1'b0;
            lo       <= '0;
            m_addr   <= base;
            done     <= (n_out == '0);
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                m_addr <= m_addr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end else if (push) begin
                overflow <= 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop) begin
                count <= count - 1'b1;
            end
            if (take) begin
                taken <= taken_nxt;
                if (push) begin
                    half <= 1'b0;
                end else begin
                    lo   <= red;
                    half <= 1'b1;
                end
            end
            case (state)
                S_PACK: begin
                    if (take && last) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((count == '0) || ((count == 1) && pop)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
